// File: rtl/arb2x1_3s.sv
// Two-requester round-robin arbiter driving select/enable of the shared mux2x1_3s bus.
// Optional one-cycle bus turnaround on handover: define ARB2X1_TURNAROUND_EN.
module arb2x1_3s #(
    parameter int unsigned MAXBURST = 4,
    parameter int unsigned CW       = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic sel,
    output logic oe,
    output logic busy
);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAXBURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2,
        TA   = 2'd3
    } state_t;

    // Target state for a direct handover toward each requester.
`ifdef ARB2X1_TURNAROUND_EN
    localparam state_t TO_G0 = TA;
    localparam state_t TO_G1 = TA;
`else
    localparam state_t TO_G0 = G0;
    localparam state_t TO_G1 = G1;
`endif

    state_t        state, state_nx, idle_pick;
    logic [CW-1:0] cnt, cnt_nx;
    logic          last, last_nx;
    logic          sel_nx;
    logic          gnt0_nx, gnt1_nx, oe_nx, busy_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            sel   <= 1'b0;
            oe    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            last  <= last_nx;
            gnt0  <= gnt0_nx;
            gnt1  <= gnt1_nx;
            sel   <= sel_nx;
            oe    <= oe_nx;
            busy  <= busy_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last;
        sel_nx   = sel;

        // Arbitration from a free bus; a tie goes to whoever was not served last.
        if (req0 && req1) begin
            idle_pick = last ? G0 : G1;
        end else if (req0) begin
            idle_pick = G0;
        end else if (req1) begin
            idle_pick = G1;
        end else begin
            idle_pick = IDLE;
        end

        case (state)
            IDLE: state_nx = idle_pick;
            G0: begin
                if (!req0) begin
                    state_nx = req1 ? TO_G1 : IDLE;
                end else if (req1 && (cnt == CNT_MAX)) begin
                    state_nx = TO_G1;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            G1: begin
                if (!req1) begin
                    state_nx = req0 ? TO_G0 : IDLE;
                end else if (req0 && (cnt == CNT_MAX)) begin
                    state_nx = TO_G0;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = idle_pick;
        endcase

        // Entry into a grant state restarts the burst and records the owner.
        if ((state_nx == G0) && (state != G0)) begin
            cnt_nx  = '0;
            last_nx = 1'b0;
        end
        if ((state_nx == G1) && (state != G1)) begin
            cnt_nx  = '0;
            last_nx = 1'b1;
        end

        case (state_nx)
            G0:      sel_nx = 1'b0;
            G1:      sel_nx = 1'b1;
            TA:      sel_nx = (state == G0);
            default: sel_nx = sel;
        endcase

        gnt0_nx = (state_nx == G0);
        gnt1_nx = (state_nx == G1);
        oe_nx   = gnt0_nx | gnt1_nx;
        busy_nx = gnt0_nx | gnt1_nx | (state_nx == TA);
    end

    a_gnt_onehot: assert property (@(posedge clk) !(gnt0 && gnt1));
    a_oe_matches: assert property (@(posedge clk) oe == (gnt0 | gnt1));

endmodule

// File: tb/tb_arb2x1_3s.sv
// Directed self-checking bench for arb2x1_3s (MAXBURST=4 and MAXBURST=1 instances).
module tb_arb2x1_3s;

    logic clk = 1'b0;
    logic rst, req0, req1;
    logic gnt0, gnt1, sel, oe, busy;
    logic b_gnt0, b_gnt1, b_sel, b_oe, b_busy;
    int   errs   = 0;
    int   checks = 0;

    // Packed view: {gnt0, gnt1, sel, oe, busy}
    localparam logic [4:0] O_RST  = 5'b00000;
    localparam logic [4:0] O_G0   = 5'b10011;
    localparam logic [4:0] O_G1   = 5'b01111;
    localparam logic [4:0] O_TA1  = 5'b00101;
    localparam logic [4:0] O_TA0  = 5'b00001;
    localparam logic [4:0] O_ID1  = 5'b00100;

    always #5 clk = ~clk;

    arb2x1_3s #(.MAXBURST(4), .CW(3)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .oe(oe), .busy(busy)
    );

    arb2x1_3s #(.MAXBURST(1), .CW(1)) dut_b1 (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .sel(b_sel), .oe(b_oe), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b (gnt0,gnt1,sel,oe,busy)", tag, got, exp);
        end
    endtask

    task automatic step(input logic r0, input logic r1, input logic rs);
        req0 = r0;
        req1 = r1;
        rst  = rs;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] obs();
        return {gnt0, gnt1, sel, oe, busy};
    endfunction

    function automatic logic [4:0] obs_b1();
        return {b_gnt0, b_gnt1, b_sel, b_oe, b_busy};
    endfunction

    // Expected owner pattern when both requesters are held from a free bus.
    function automatic logic [4:0] exp_cont(input int i);
`ifdef ARB2X1_TURNAROUND_EN
        if (i < 4)  return O_G0;
        if (i == 4) return O_TA1;
        if (i < 9)  return O_G1;
        if (i == 9) return O_TA0;
        return O_G0;
`else
        return ((i / 4) % 2 == 0) ? O_G0 : O_G1;
`endif
    endfunction

    function automatic logic [4:0] exp_cont_b1(input int i);
`ifdef ARB2X1_TURNAROUND_EN
        case (i % 4)
            0:       return O_G0;
            1:       return O_TA1;
            2:       return O_G1;
            default: return O_TA0;
        endcase
`else
        return (i % 2 == 0) ? O_G0 : O_G1;
`endif
    endfunction

    initial begin
        int n_cont;
`ifdef ARB2X1_TURNAROUND_EN
        n_cont = 14;
`else
        n_cont = 12;
`endif
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;

        // Reset held with both requests pending.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b1);
            chk("reset", obs(), O_RST);
            chk("reset_b1", obs_b1(), O_RST);
        end

        // Contention from IDLE; first edge after reset goes to req0.
        for (int i = 0; i < n_cont; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk($sformatf("contend_%0d", i), obs(), exp_cont(i));
            chk($sformatf("contend_b1_%0d", i), obs_b1(), exp_cont_b1(i));
        end

        step(1'b0, 1'b0, 1'b0);
        chk("release_both", obs(), O_RST);

        // Lone requester keeps the bus; sel holds after release.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("single_r1_%0d", i), obs(), O_G1);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("single_release", obs(), O_ID1);

        // Early release hands over with a fresh full burst.
        step(1'b1, 1'b0, 1'b0);
        chk("early_g0_a", obs(), O_G0);
        step(1'b1, 1'b1, 1'b0);
        chk("early_g0_b", obs(), O_G0);
        step(1'b0, 1'b1, 1'b0);
`ifdef ARB2X1_TURNAROUND_EN
        chk("early_ta", obs(), O_TA1);
        step(1'b1, 1'b1, 1'b0);
`endif
        chk("early_g1_0", obs(), O_G1);
        for (int i = 1; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk($sformatf("early_g1_%0d", i), obs(), O_G1);
        end
        step(1'b1, 1'b1, 1'b0);
`ifdef ARB2X1_TURNAROUND_EN
        chk("early_preempt", obs(), O_TA0);
`else
        chk("early_preempt", obs(), O_G0);
`endif

        // Reset in the middle of a G1 grant.
        step(1'b0, 1'b0, 1'b0);
        chk("pre_rst_idle", obs(), O_RST);
        step(1'b0, 1'b1, 1'b0);
        chk("pre_rst_g1_a", obs(), O_G1);
        step(1'b1, 1'b1, 1'b0);
        chk("pre_rst_g1_b", obs(), O_G1);
        step(1'b1, 1'b1, 1'b1);
        chk("mid_rst", obs(), O_RST);
        step(1'b1, 1'b1, 1'b0);
        chk("post_rst_g0", obs(), O_G0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/arb2x1_3s.md
# arb2x1_3s

Two-requester round-robin arbiter that owns the select and output-enable of the shared 2:1 tri-state mux (`mux2x1_3s`), so two sources can take turns on one bus without contention. Each requester holds `reqN` while it needs the bus. The arbiter issues registered grants and drives the mux select `s` and tri-state enable. A burst limit enforces fairness. Outputs wire straight to the mux; grants return to the requesters.

## Interface
- `MAXBURST`, 4: max consecutive grant cycles one requester keeps while the other waits; legal range ≥1.
- `CW`, 3: burst counter width; must satisfy 2^CW > MAXBURST-1.

- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req0`  in  1  requester 0 wants the bus (level, held until done).
- `req1`  in  1  requester 1 wants the bus.
- `gnt0`  out  1  requester 0 owns the bus this cycle.
- `gnt1`  out  1  requester 1 owns the bus this cycle.
- `sel`  out  1  mux select `s`: 0 selects `a0`, 1 selects `a1`.
- `oe`  out  1  mux output enable; 0 → mux output `y` high-Z.
- `busy`  out  1  `gnt0 | gnt1`, plus TA state when configured.

## Operation
- States: IDLE, G0, G1, TA (TA exists only with the macro).
- Internal `last` bit = last requester served. Internal `cnt[CW-1:0]` = grant-cycle counter.
- IDLE:
  - Only req0 → G0. Only req1 → G1.
  - Both → grant the requester ≠ `last`.
  - Neither → stay.
- G0, each edge:
  - req0=0: req1 → G1 (or TA), else IDLE.
  - req0=1, req1=1, cnt==MAXBURST-1 → preempt to G1 (or TA).
  - Otherwise stay; cnt increments, saturating at MAXBURST-1.
- G1 is symmetric with G0.
- Entering G0/G1 sets cnt=0 and updates `last` to the new owner.
- `sel` = 0 in G0, 1 in G1. It holds its previous value in IDLE, so `s` never toggles without a grant.
- `oe` = 1 only in G0/G1.
- `gnt0`/`gnt1` are one-hot or zero, never both 1.
- All outputs are registered, with no combinational path from req to outputs.
- A lone requester with no competitor keeps the grant indefinitely; the burst limit applies only under contention.

## Timing
- Reset values: gnt0=0, gnt1=0, sel=0, oe=0, busy=0. Internal: state=IDLE, cnt=0, last=1, so req0 wins the first tie.
- Grant latency: req sampled high at edge k in IDLE → gnt/oe/sel valid after edge k.
- Release: req dropped before edge k → gnt=0 after edge k (IDLE or handover).
- Direct handover, no macro:
  - gnt0 falls and gnt1 rises on the same edge.
  - sel flips on that edge; oe stays 1.
- Contention, both held continuously: owner alternates every MAXBURST cycles.
- MAXBURST=1 with both requesting: alternate every cycle.
- Simultaneous req rise from IDLE: resolved by `last`, never both granted.
- rst asserted mid-grant:
  - Outputs return to reset values after that edge.
  - A still-held request is re-granted one cycle after rst deasserts, by tie rule with last=1.
- req withdrawn during TA: TA still completes (1 cycle), then the normal IDLE evaluation runs.

## Configuration
- `ARB2X1_TURNAROUND_EN` defined:
  - Every direct G0↔G1 handover passes through TA for exactly one cycle.
  - In TA: gnt0=gnt1=0, oe=0 (bus high-Z), sel already switched to the incoming owner, busy=1.
  - Incoming owner is granted on the following edge. Handover latency is 2 edges.
  - IDLE→Gx is unaffected.
- Undefined: TA state not built. Handover is back-to-back as in Timing.

## Test plan
- Reset: hold rst=1 for 2 cycles with req0=req1=1 → gnt0=gnt1=0, oe=0, sel=0. First edge after rst=0 → gnt0=1, sel=0, oe=1.
- Single requester: req1=1 for 10 cycles, req0=0 → gnt1=1, sel=1 for all 10 cycles, no preemption. req1=0 → next edge gnt1=0, oe=0, sel stays 1.
- Contention, MAXBURST=4, no macro: req0=req1=1 from IDLE → grants G0×4, G1×4, G0×4. gnt never both 1; oe constantly 1.
- Contention with `ARB2X1_TURNAROUND_EN`: same stimulus → G0×4, TA×1 (oe=0, sel=1), G1×4, TA×1 (sel=0), G0×4.
- Early release: G0 active with cnt=1, req0 drops, req1=1 → next edge gnt1=1, cnt restarts at 0, full 4-cycle burst for req1.
- Mid-grant reset: in G1 assert rst for 1 cycle with both reqs held → outputs reset after that edge. Next edge gnt0=1, since last reset to 1.
